// File: rtl/hazard_sched.sv
// Hazard/stall scheduler for the 5-stage core: load-use bubbles, EX redirects,
// data-memory wait states with timeout, debug halt drain, and stall/flush counters.
module hazard_sched #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255,
  parameter int DRAIN_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             pipe_freeze,
  output logic             halt_ack,
  output logic             mem_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] S_RUN      = 3'd0;
  localparam logic [2:0] S_MEM_WAIT = 3'd1;
  localparam logic [2:0] S_DRAIN    = 3'd2;
  localparam logic [2:0] S_HALTED   = 3'd3;
  localparam logic [2:0] S_ERR      = 3'd4;

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [WW-1:0] TIMEOUT_V  = WW'(MEM_TIMEOUT);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic mem_busy;

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_busy = mem_req && !mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    mem_err_d   = mem_err_q;
    case (state_q)
      S_RUN: begin
        if (mem_busy) begin
          wait_cnt_d = WW'(1);
          if (MEM_TIMEOUT == 1) begin
            state_d   = S_ERR;
            mem_err_d = 1'b1;
          end else begin
            state_d = S_MEM_WAIT;
          end
        end else if (!ex_redirect && !load_use && halt_req) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      // Redirect and halt are deliberately not sampled here; EX is frozen so they persist.
      S_MEM_WAIT: begin
        if (!mem_busy) begin
          wait_cnt_d = '0;
          state_d    = S_RUN;
        end else if (wait_cnt_q == TIMEOUT_V) begin
          state_d   = S_ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!halt_req) begin
          state_d     = S_RUN;
          drain_cnt_d = '0;
        end else if (!mem_busy) begin
          if (drain_cnt_q == DRAIN_LAST) state_d = S_HALTED;
          else drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_HALTED: begin
        if (!halt_req) state_d = S_RUN;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d     = S_RUN;
        wait_cnt_d  = '0;
        drain_cnt_d = '0;
      end
    endcase
  end

  // Gated by rst so every control reads 0 while reset is held, whatever the inputs do.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    halt_ack    = 1'b0;
    if (rst) begin
      case (state_q)
        S_RUN: begin
          if (mem_busy) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            pipe_freeze = 1'b1;
          end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          pc_stall    = mem_busy;
          ifid_stall  = mem_busy;
          idex_stall  = mem_busy;
          pipe_freeze = mem_busy;
        end
        S_DRAIN: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          pipe_freeze = mem_busy;
          ifid_flush  = ex_redirect;
          idex_flush  = ex_redirect;
        end
        S_HALTED: begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
          halt_ack   = 1'b1;
        end
        S_ERR: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          pipe_freeze = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  assign mem_err   = mem_err_q;
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Scoreboard bench for hazard_sched: driver queues hand-computed expectations per
// cycle, a negedge monitor pops and compares all outputs.
module tb_hazard_sched;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0, ex_redirect = 0;
  logic mem_req = 0, mem_ready = 0, halt_req = 0;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, pipe_freeze;
  logic halt_ack, mem_err;
  logic [2:0] state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_sched #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .DRAIN_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .pipe_freeze(pipe_freeze),
    .halt_ack(halt_ack), .mem_err(mem_err), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // ctl bits: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, pipe_freeze, halt_ack, mem_err}
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_LU    = 8'b1101_0000;
  localparam logic [7:0] C_FLUSH = 8'b0010_1000;
  localparam logic [7:0] C_FRZ   = 8'b1101_0100;
  localparam logic [7:0] C_DRAIN = 8'b1101_0000;
  localparam logic [7:0] C_DRRED = 8'b1111_1000;
  localparam logic [7:0] C_HALT  = 8'b1101_0010;
  localparam logic [7:0] C_ERR   = 8'b1101_0101;

  typedef struct {
    string      nm;
    logic [7:0] ctl;
    logic [2:0] st;
    int         sc;
    int         fc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic next_cyc();
    @(posedge clk);
    #1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0; ex_redirect = 0;
    mem_req = 0; mem_ready = 0; halt_req = 0;
  endtask

  task automatic expect_out(input string nm, input logic [7:0] ctl, input logic [2:0] st,
                            input int sc, input int fc);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.st = st; e.sc = sc; e.fc = fc;
    sb.push_back(e);
  endtask

  task automatic set_lu_rs1();
    ex_memread = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1; id_rs2 = 5'd1; id_use_rs2 = 1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [7:0] act;
      e = sb.pop_front();
      act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, pipe_freeze, halt_ack, mem_err};
      n_checks++;
      if (act === e.ctl && state === e.st && int'(stall_cnt) == e.sc && int'(flush_cnt) == e.fc) begin
        n_pass++;
        $display("ok   %-14s ctl=%b state=%0d stall_cnt=%0d flush_cnt=%0d",
                 e.nm, act, state, stall_cnt, flush_cnt);
      end else begin
        $display("FAIL %-14s got ctl=%b state=%0d stall_cnt=%0d flush_cnt=%0d, want ctl=%b state=%0d stall_cnt=%0d flush_cnt=%0d",
                 e.nm, act, state, stall_cnt, flush_cnt, e.ctl, e.st, e.sc, e.fc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired with %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    next_cyc(); expect_out("reset", C_NONE, 3'd0, 0, 0);
    next_cyc(); rst = 1; expect_out("idle", C_NONE, 3'd0, 0, 0);
    // load-use
    next_cyc(); set_lu_rs1(); expect_out("lu_rs1", C_LU, 3'd0, 0, 0);
    next_cyc(); expect_out("lu_clear", C_NONE, 3'd0, 1, 0);
    next_cyc(); ex_memread = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
                expect_out("lu_rd0", C_NONE, 3'd0, 1, 0);
    next_cyc(); ex_memread = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 0; id_rs1 = 5'd3; id_use_rs1 = 1;
                expect_out("lu_nouse2", C_NONE, 3'd0, 1, 0);
    next_cyc(); ex_memread = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1;
                expect_out("lu_rs2", C_LU, 3'd0, 1, 0);
    next_cyc(); set_lu_rs1(); ex_redirect = 1; expect_out("redir_lu", C_FLUSH, 3'd0, 2, 0);
    next_cyc(); expect_out("after_redir", C_NONE, 3'd0, 2, 1);
    // three-cycle memory wait
    next_cyc(); mem_req = 1; expect_out("mem_run", C_FRZ, 3'd0, 2, 1);
    next_cyc(); mem_req = 1; ex_redirect = 1; halt_req = 1; expect_out("mem_wait1", C_FRZ, 3'd1, 3, 1);
    next_cyc(); mem_req = 1; expect_out("mem_wait2", C_FRZ, 3'd1, 4, 1);
    next_cyc(); mem_req = 1; mem_ready = 1; expect_out("mem_done", C_NONE, 3'd1, 5, 1);
    next_cyc(); expect_out("mem_back_run", C_NONE, 3'd0, 5, 1);
    // halt drain and release
    next_cyc(); halt_req = 1; expect_out("halt_req", C_NONE, 3'd0, 5, 1);
    next_cyc(); halt_req = 1; expect_out("drain0", C_DRAIN, 3'd2, 5, 1);
    next_cyc(); halt_req = 1; expect_out("drain1", C_DRAIN, 3'd2, 6, 1);
    next_cyc(); halt_req = 1; expect_out("drain2", C_DRAIN, 3'd2, 7, 1);
    next_cyc(); halt_req = 1; expect_out("drain3", C_DRAIN, 3'd2, 8, 1);
    next_cyc(); halt_req = 1; expect_out("halted", C_HALT, 3'd3, 9, 1);
    next_cyc(); expect_out("halt_release", C_HALT, 3'd3, 10, 1);
    next_cyc(); expect_out("halt_to_run", C_NONE, 3'd0, 11, 1);
    // drain aborted, redirect during drain
    next_cyc(); halt_req = 1; expect_out("halt_req2", C_NONE, 3'd0, 11, 1);
    next_cyc(); halt_req = 1; ex_redirect = 1; expect_out("drain_redir", C_DRRED, 3'd2, 11, 1);
    next_cyc(); expect_out("drain_abort", C_DRAIN, 3'd2, 12, 2);
    next_cyc(); expect_out("abort_run", C_NONE, 3'd0, 13, 2);
    // timeout: five not-ready cycles, stall_cnt saturates at 15
    next_cyc(); mem_req = 1; expect_out("to_run", C_FRZ, 3'd0, 13, 2);
    next_cyc(); mem_req = 1; expect_out("to_wait1", C_FRZ, 3'd1, 14, 2);
    next_cyc(); mem_req = 1; expect_out("to_wait2", C_FRZ, 3'd1, 15, 2);
    next_cyc(); mem_req = 1; expect_out("to_wait3", C_FRZ, 3'd1, 15, 2);
    next_cyc(); mem_req = 1; expect_out("to_wait4", C_FRZ, 3'd1, 15, 2);
    next_cyc(); expect_out("err", C_ERR, 3'd4, 15, 2);
    next_cyc(); ex_redirect = 1; mem_req = 1; mem_ready = 1; expect_out("err_sticky", C_ERR, 3'd4, 15, 2);
    // reset clears ERR, then reset in the middle of a memory wait
    next_cyc(); rst = 0; mem_req = 1; expect_out("rst_in_err", C_NONE, 3'd0, 0, 0);
    next_cyc(); rst = 1; mem_req = 1; expect_out("mem_run2", C_FRZ, 3'd0, 0, 0);
    next_cyc(); mem_req = 1; expect_out("mem_wait_r", C_FRZ, 3'd1, 1, 0);
    next_cyc(); rst = 0; mem_req = 1; expect_out("rst_in_wait", C_NONE, 3'd0, 0, 0);
    next_cyc(); rst = 1; expect_out("post_reset", C_NONE, 3'd0, 0, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain_sb got %0d pending, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
